spi_m: RTL and testbench

Host-side 3-wire SPI master that generates the serial clock, chip select and the bidirectional data line for the `spi_s` register-file slave. It accepts single-register read/write commands from a parallel host port and serialises each as one chip-select frame. The frame carries instruction bits, then a register address, then either write data driven by the master or read data returned by the slave. The block sits directly upstream of the slave and owns all `sclk` generation.

---
 rtl/spi_m.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_m.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_m.sv
// -----------------------------------------------------------------------------
// spi_m : host-side 3-wire SPI master for the spi_s register-file slave.
//
// Each accepted command becomes one chip-select frame:
//   LEAD (1 dummy period, sdio=0) -> INST (2 bits, 11=read / 00=write)
//   -> ADDR (A_WIDTH bits, MSB first)
//   -> WDATA (D_WIDTH bits driven)  or  TURN (1 period, released) -> RDATA
//   -> HOLD (cs high for CS_GAP periods) -> IDLE
//
// One bit period is T = 2*CLK_DIV clk cycles. The master changes its data
// bit on the clk edge that drops sclk (period start), raises sclk CLK_DIV
// cycles later, and drops it again at period end. Read bits are captured on
// the clk edge that raises sclk.
//
// Handshake: start is sampled only while idle (busy low). On acceptance the
// command fields are latched and busy rises in the following cycle; busy
// stays high through the post-frame cs hold. done pulses for one cycle at
// frame end; rdata is updated in that same cycle for reads and otherwise
// holds. start while busy is dropped, not queued.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start, rw         command request, 1 = read / 0 = write
//   addr, wdata       register address and write data
//   busy, done        command in flight, one-cycle end-of-frame pulse
//   rdata             last read word
//   sclk, cs, sdio    serial clock (idle low), chip select (active low),
//                     bidirectional data line
//   dbg_state         current FSM state, for observation only
// -----------------------------------------------------------------------------
module spi_m #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 16,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               rw,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] wdata,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] rdata,
    output logic               sclk,
    output logic               cs,
    inout  wire                sdio,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_INST  = 3'd2,
        S_ADDR  = 3'd3,
        S_WDATA = 3'd4,
        S_TURN  = 3'd5,
        S_RDATA = 3'd6,
        S_HOLD  = 3'd7
    } state_t;

    // Phase counter runs 0 .. 2*CLK_DIV-1 within one bit period.
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(2 * CLK_DIV - 1);

    // Bit counter counts periods inside a state; sized for the longest state.
    localparam int AD_MAX  = (A_WIDTH > D_WIDTH) ? A_WIDTH : D_WIDTH;
    localparam int BIT_MAX = (AD_MAX > CS_GAP) ? AD_MAX : CS_GAP;
    localparam int BIT_W   = $clog2(BIT_MAX + 1);
    localparam logic [BIT_W-1:0] INST_LAST = BIT_W'(1);
    localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(A_WIDTH - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(D_WIDTH - 1);
    localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'(CS_GAP - 1);

    // Outgoing shift register: {inst[1:0], addr, wdata}, consumed MSB first.
    localparam int SH_W = 2 + A_WIDTH + D_WIDTH;

    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [BIT_W-1:0]   bit_q;
    logic [SH_W-1:0]    sh_q;
    logic [D_WIDTH-1:0] rx_q;
    logic               rw_q;
    logic               sclk_q;
    logic               cs_q;
    logic               drive_q;
    logic               sdo_q;
    logic               busy_q;
    logic               done_q;
    logic [D_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            rw_q    <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            drive_q <= 1'b0;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rw_q    <= rw;
                        sh_q    <= {rw, rw, addr, wdata};
                        cs_q    <= 1'b0;
                        drive_q <= 1'b1;
                        sdo_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        sclk_q  <= 1'b0;
                        div_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_LEAD;
                    end
                end

                // cs and sclk stay idle; only the period count advances.
                S_HOLD: begin
                    if (div_q == DIV_END) begin
                        div_q <= '0;
                        if (bit_q == GAP_LAST) begin
                            bit_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                // All in-frame states share the sclk waveform.
                default: begin
                    if (div_q == DIV_RISE) begin
                        sclk_q <= 1'b1;
                        // sdio here is the value held before this edge.
                        if (state_q == S_RDATA) begin
                            rx_q <= {rx_q[D_WIDTH-2:0], sdio};
                        end
                    end

                    if (div_q == DIV_END) begin
                        div_q  <= '0;
                        sclk_q <= 1'b0;
                        case (state_q)
                            S_LEAD: begin
                                sdo_q   <= sh_q[SH_W-1];
                                sh_q    <= sh_q << 1;
                                bit_q   <= '0;
                                state_q <= S_INST;
                            end

                            S_INST: begin
                                sdo_q <= sh_q[SH_W-1];
                                sh_q  <= sh_q << 1;
                                if (bit_q == INST_LAST) begin
                                    bit_q   <= '0;
                                    state_q <= S_ADDR;
                                end else begin
                                    bit_q <= bit_q + 1'b1;
                                end
                            end

                            S_ADDR: begin
                                if (bit_q == ADDR_LAST) begin
                                    bit_q <= '0;
                                    if (rw_q) begin
                                        // Release the line for the whole
                                        // turnaround so the slave can take it.
                                        drive_q <= 1'b0;
                                        state_q <= S_TURN;
                                    end else begin
                                        sdo_q   <= sh_q[SH_W-1];
                                        sh_q    <= sh_q << 1;
                                        state_q <= S_WDATA;
                                    end
                                end else begin
                                    sdo_q <= sh_q[SH_W-1];
                                    sh_q  <= sh_q << 1;
                                    bit_q <= bit_q + 1'b1;
                                end
                            end

                            S_WDATA: begin
                                if (bit_q == DATA_LAST) begin
                                    bit_q   <= '0;
                                    cs_q    <= 1'b1;
                                    drive_q <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= S_HOLD;
                                end else begin
                                    sdo_q <= sh_q[SH_W-1];
                                    sh_q  <= sh_q << 1;
                                    bit_q <= bit_q + 1'b1;
                                end
                            end

                            S_TURN: begin
                                bit_q   <= '0;
                                state_q <= S_RDATA;
                            end

                            S_RDATA: begin
                                if (bit_q == DATA_LAST) begin
                                    bit_q   <= '0;
                                    cs_q    <= 1'b1;
                                    done_q  <= 1'b1;
                                    rdata_q <= rx_q;
                                    state_q <= S_HOLD;
                                end else begin
                                    bit_q <= bit_q + 1'b1;
                                end
                            end

                            default: state_q <= S_IDLE;
                        endcase
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign sdio      = drive_q ? sdo_q : 1'bz;
    assign sclk      = sclk_q;
    assign cs        = cs_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_m.sv
// -----------------------------------------------------------------------------
// tb_spi_m : directed bench for spi_m with a behavioural spi_s slave model.
// Two masters are instantiated (CLK_DIV=4 and CLK_DIV=1); `sel` picks which
// one is stimulated and watched. Expected sdio bits, frame lengths, cs gaps
// and rdata values are queued when a command is issued and consumed by the
// monitor as the frame appears on the wires.
// -----------------------------------------------------------------------------
module tb_spi_m;

    localparam int GT = 2 * 2 * 4;  // CS_GAP * T for the CLK_DIV=4 master

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        sel = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    wire       start4 = start & ~sel;
    wire       start1 = start & sel;
    wire       busy4, done4, sclk4, cs4, busy1, done1, sclk1, cs1;
    wire [7:0] rdata4, rdata1;
    wire [2:0] st4, st1;
    wire       sdio4, sdio1;

    spi_m #(.D_WIDTH(8), .A_WIDTH(16), .CLK_DIV(4), .CS_GAP(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy4), .done(done4), .rdata(rdata4),
        .sclk(sclk4), .cs(cs4), .sdio(sdio4), .dbg_state(st4)
    );

    spi_m #(.D_WIDTH(8), .A_WIDTH(16), .CLK_DIV(1), .CS_GAP(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy1), .done(done1), .rdata(rdata1),
        .sclk(sclk1), .cs(cs1), .sdio(sdio1), .dbg_state(st1)
    );

    // Slave model drives the selected master's line.
    logic slv_en = 1'b0;
    logic slv_bit = 1'b0;
    assign sdio4 = (slv_en && !sel) ? slv_bit : 1'bz;
    assign sdio1 = (slv_en && sel) ? slv_bit : 1'bz;

    wire       m_busy  = sel ? busy1 : busy4;
    wire       m_done  = sel ? done1 : done4;
    wire [7:0] m_rdata = sel ? rdata1 : rdata4;
    wire       m_sclk  = sel ? sclk1 : sclk4;
    wire       m_cs    = sel ? cs1 : cs4;
    wire       m_sdio  = sel ? sdio1 : sdio4;
    wire [2:0] m_state = sel ? st1 : st4;
    wire       m_drive = sel ? u_dut1.drive_q : u_dut4.drive_q;

    // ---------------- scoreboard ----------------
    logic [1:0] exp_bit_q[$];   // 0/1 = bit on sdio, 2 = master must not drive
    logic [7:0] exp_q[$];       // rdata expected at each done
    int         exp_len_q[$];   // cs-low cycles per frame
    int         exp_gap_q[$];   // cs-high cycles before the next frame

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model + monitor ----------------
    logic [7:0]  mem [0:65535];
    logic [31:0] slv_sr = '0;
    logic [1:0]  slv_inst = 2'b10;
    logic [15:0] slv_addr = '0;
    logic [7:0]  slv_tx = '0;
    int          slv_cnt = 0;

    logic prev_sclk = 1'b0;
    logic prev_cs = 1'b1;
    logic abort_frame = 1'b0;
    int   cyc = 0;
    int   low_cnt = 0;
    int   high_cnt = 0;
    int   last_rise = -1;
    int   cs_falls = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        logic [1:0] e;
        cyc++;
        if (m_done) begin
            done_cnt++;
            if (exp_q.size() > 0) chk("rdata_at_done", m_rdata, exp_q.pop_front());
            else chk("done_expected", exp_q.size(), 1);
        end
        if (!m_cs) begin
            if (prev_cs) begin
                cs_falls++;
                if (exp_gap_q.size() > 0) chk("cs_gap", high_cnt, exp_gap_q.pop_front());
                low_cnt   = 0;
                slv_cnt   = 0;
                slv_inst  = 2'b10;
                last_rise = -1;
            end
            low_cnt++;
            if (m_sclk && !prev_sclk) begin
                if (last_rise >= 0) chk("sclk_period", cyc - last_rise, sel ? 2 : 8);
                last_rise = cyc;
                if (exp_bit_q.size() == 0) begin
                    chk("bit_available", exp_bit_q.size(), 1);
                end else begin
                    e = exp_bit_q.pop_front();
                    if (e == 2'd2) chk("sdio_released", m_drive, 0);
                    else chk("sdio_bit", m_sdio, e[0]);
                end
                slv_sr = {slv_sr[30:0], m_sdio};
                slv_cnt++;
                if (slv_cnt == 3) slv_inst = slv_sr[1:0];
                if (slv_cnt == 19) slv_addr = slv_sr[15:0];
            end else if (!m_sclk && prev_sclk) begin
                if (slv_inst == 2'b11 && slv_cnt >= 20) begin
                    if (slv_cnt == 20) begin
                        slv_tx = mem[slv_addr];
                        slv_en = 1'b1;
                    end else begin
                        slv_tx = slv_tx << 1;
                    end
                    slv_bit = slv_tx[7];
                end
            end
        end else begin
            if (!prev_cs) begin
                if (slv_inst == 2'b00 && slv_cnt == 27) mem[slv_addr] = slv_sr[7:0];
                if (abort_frame) abort_frame = 1'b0;
                else if (exp_len_q.size() > 0) chk("cs_low_cycles", low_cnt, exp_len_q.pop_front());
                else chk("frame_expected", exp_len_q.size(), 1);
                high_cnt = 0;
            end
            high_cnt++;
            slv_en = 1'b0;
        end
        prev_sclk = m_sclk;
        prev_cs   = m_cs;
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame(input logic r, input logic [15:0] a, input logic [7:0] d);
        int per;
        per = sel ? 2 : 8;
        exp_bit_q.push_back(2'd0);
        exp_bit_q.push_back({1'b0, r});
        exp_bit_q.push_back({1'b0, r});
        for (int i = 15; i >= 0; i--) exp_bit_q.push_back({1'b0, a[i]});
        if (r) exp_bit_q.push_back(2'd2);
        for (int i = 7; i >= 0; i--) exp_bit_q.push_back({1'b0, d[i]});
        exp_len_q.push_back((r ? 28 : 27) * per);
    endtask

    logic [7:0] rd_model = '0;

    task automatic expect_cmd(input logic r, input logic [15:0] a, input logic [7:0] d);
        push_frame(r, a, d);
        if (r) rd_model = d;
        exp_q.push_back(rd_model);
    endtask

    task automatic issue(input logic r, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        rw = r; addr = a; wdata = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (m_done) break;
        end
        chk("done_seen", m_done, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("back_to_idle", m_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int f0;
        int d0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h00FF] = 8'h3C;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", cs4, 1);
        chk("rst_sclk", sclk4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_rdata", rdata4, 0);
        chk("rst_drive", u_dut4.drive_q, 0);
        chk("rst_state", st4, 0);
        chk("rst_cs_div1", cs1, 1);
        rst_n = 1'b1;

        // Write 0xA5 to 0x1234
        f0 = cs_falls; d0 = done_cnt;
        expect_cmd(1'b0, 16'h1234, 8'hA5);
        issue(1'b0, 16'h1234, 8'hA5);
        chk("busy_after_start", m_busy, 1);
        wait_done(lat);
        chk("write_latency", lat, 217);
        @(negedge clk);
        chk("done_one_cycle", m_done, 0);
        wait_idle();
        chk("write_mem", mem[16'h1234], 8'hA5);
        chk("write_frames", cs_falls - f0, 1);
        chk("write_dones", done_cnt - d0, 1);

        // Read 0x00FF -> 0x3C
        expect_cmd(1'b1, 16'h00FF, 8'h3C);
        issue(1'b1, 16'h00FF, 8'h00);
        wait_done(lat);
        chk("read_latency", lat, 225);
        chk("read_rdata", m_rdata, 8'h3C);
        wait_idle();

        // Busy rejection: start pulses mid-ADDR and in HOLD are dropped
        f0 = cs_falls; d0 = done_cnt;
        expect_cmd(1'b0, 16'h0042, 8'h5A);
        issue(1'b0, 16'h0042, 8'h5A);
        repeat (40) @(posedge clk);
        #1;
        chk("in_addr", m_state, 3);
        rw = 1'b1; addr = 16'hFFFF; wdata = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_mid_frame", m_busy, 1);
        wait_done(lat);
        #2;
        rw = 1'b1; addr = 16'hEEEE; wdata = 8'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rw = 1'b0;
        chk("in_hold", m_state, 7);
        repeat (GT - 1) @(negedge clk);
        chk("busy_hold_last", m_busy, 1);
        @(negedge clk);
        chk("busy_hold_end", m_busy, 0);
        repeat (20) @(negedge clk);
        chk("reject_frames", cs_falls - f0, 1);
        chk("reject_dones", done_cnt - d0, 1);
        chk("reject_mem", mem[16'h0042], 8'h5A);
        chk("reject_no_ffff", mem[16'hFFFF], 8'h00);

        // Back-to-back with start held high
        f0 = cs_falls; d0 = done_cnt;
        expect_cmd(1'b0, 16'h0100, 8'h11);
        expect_cmd(1'b0, 16'h0100, 8'h11);
        @(posedge clk); #1;
        rw = 1'b0; addr = 16'h0100; wdata = 8'h11; start = 1'b1;
        wait_done(lat);
        exp_gap_q.push_back(GT + 1);
        wait_done(lat);
        start = 1'b0;
        wait_idle();
        chk("b2b_frames", cs_falls - f0, 2);
        chk("b2b_dones", done_cnt - d0, 2);
        chk("b2b_gap_used", exp_gap_q.size(), 0);

        // Reset during WDATA
        f0 = done_cnt;
        expect_cmd(1'b0, 16'h0200, 8'h77);
        issue(1'b0, 16'h0200, 8'h77);
        repeat (170) @(posedge clk);
        #2;
        chk("in_wdata", m_state, 4);
        abort_frame = 1'b1;
        exp_bit_q.delete();
        exp_len_q.delete();
        exp_q.delete();
        rd_model = 8'h00;
        rst_n = 1'b0;
        #1;
        chk("abort_cs", m_cs, 1);
        chk("abort_sclk", m_sclk, 0);
        chk("abort_drive", m_drive, 0);
        chk("abort_busy", m_busy, 0);
        chk("abort_done", m_done, 0);
        chk("abort_rdata", m_rdata, 0);
        chk("abort_state", m_state, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_no_done", done_cnt - f0, 0);
        chk("abort_no_store", mem[16'h0200], 8'h00);
        expect_cmd(1'b0, 16'h0300, 8'hC3);
        issue(1'b0, 16'h0300, 8'hC3);
        wait_done(lat);
        chk("post_reset_latency", lat, 217);
        wait_idle();
        chk("post_reset_mem", mem[16'h0300], 8'hC3);

        // CLK_DIV = 1 corner
        sel = 1'b1;
        rd_model = 8'h00;
        expect_cmd(1'b1, 16'h00FF, 8'h3C);
        issue(1'b1, 16'h00FF, 8'h00);
        wait_done(lat);
        chk("div1_read_latency", lat, 57);
        chk("div1_rdata", m_rdata, 8'h3C);
        wait_idle();
        expect_cmd(1'b0, 16'h00FE, 8'h96);
        issue(1'b0, 16'h00FE, 8'h96);
        wait_done(lat);
        chk("div1_write_latency", lat, 55);
        wait_idle();
        chk("div1_write_mem", mem[16'h00FE], 8'h96);
        expect_cmd(1'b1, 16'h00FE, 8'h96);
        issue(1'b1, 16'h00FE, 8'h00);
        wait_done(lat);
        wait_idle();
        chk("div1_rdata_hold", m_rdata, 8'h96);

        repeat (5) @(negedge clk);
        chk("bits_left", exp_bit_q.size(), 0);
        chk("frames_left", exp_len_q.size(), 0);
        chk("dones_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
